z80fi_bus_recorder: RTL and testbench
=====================================

Name: z80fi_bus_recorder

Overview:
- Producer side of the z80fi formal interface. Watches the core's machine-cycle and bus events and assembles one retired-instruction record per instruction.
- The record holds: instruction bytes, length, data-bus read/write, up to 7 M-cycle types, and T-state counts for slots 1..6.
- Drives the z80fi_* signals consumed by every z80fi_insn_spec_* checker. Sits beside the core in the formal harness.

Parameters:
MAX_MCYCLES, 7, number of M-cycle type slots (fixed by the z80fi interface; tcycles slots = MAX_MCYCLES-1)
TCYC_W, 3, width of each T-state counter (saturating)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cyc_start  in  1  pulse: first T-state of a new machine cycle
cyc_type  in  3  `CYCLE_* code of the cycle starting (valid with cyc_start)
t_tick  in  1  one pulse per T-state of the current cycle
bus_addr  in  16  address of current bus access
bus_rd  in  1  read-data strobe (bus_rdata valid this clk)
bus_rdata  in  8  read data
bus_wr  in  1  write strobe
bus_wdata  in  8  write data
insn_byte  in  1  qualifies bus_rd: byte is part of the instruction encoding
insn_done  in  1  pulse: current instruction has completed its last cycle
z80fi_valid  out  1  one-clk pulse: record outputs hold a new instruction
z80fi_insn  out  32  instruction bytes, byte n at [8n+7:8n]
z80fi_insn_len  out  3  instruction bytes captured (0..4)
z80fi_bus_raddr/z80fi_bus_rdata  out  16/8  first non-instruction read
z80fi_bus_waddr/z80fi_bus_wdata  out  16/8  first write
z80fi_mcycle_type1..7  out  3 each  cycle types in order
z80fi_tcycles1..6  out  TCYC_W each  T-states per cycle
z80fi_overflow  out  1  record exceeded slot/byte capacity

Behaviour:
- Reset (async, reset_n low):
  - All outputs 0; mcycle_type* = `CYCLE_NONE.
  - Working record cleared; state IDLE.
- States:
  - IDLE: waiting for the first cyc_start. On cyc_start, load slot 1 and go to RECORD.
  - RECORD: accumulating the working record.
  - No separate retire state; retire is a one-clk action.
- Slot handling:
  - Each cyc_start advances the slot index (1..7) and writes cyc_type into that slot.
  - An 8th cycle sets overflow; its type is discarded.
- T-state counting:
  - t_tick increments the current slot's tcycles, saturating at 2^TCYC_W-1.
  - Ticks on slot 7 are not recorded.
  - The tick coincident with cyc_start counts toward the new slot.
- Instruction bytes:
  - bus_rd && insn_byte stores bus_rdata at byte index insn_len, then insn_len++.
  - A 5th byte sets overflow and is discarded.
  - Unwritten insn bytes read as 0.
- Data read:
  - The first bus_rd with !insn_byte latches raddr/rdata.
  - Later reads are ignored.
- Data write:
  - The first bus_wr latches waddr/wdata.
  - Later writes are ignored.
- Retire (insn_done sampled high):
  - Next clk: the working record, including any same-clk events, is copied to the outputs; z80fi_valid=1 for exactly that clk.
  - Outputs then hold until the next retire.
- insn_done and cyc_start in the same clk:
  - The cycle belongs to the next instruction.
  - The retired record excludes it; the fresh record has it in slot 1 (tcycles1 starts at 1 if t_tick is also high).
- insn_done in IDLE (empty record): emit valid with len 0 and all types `CYCLE_NONE`.
- Back-to-back insn_done on consecutive clks: each produces its own valid pulse.
- Reset mid-record: the record is discarded; no valid is emitted.

Decomposition:
- `CYCLE_*` codes and the `FLAG_*` numbering come from the z80.vh package.
- Add to z80fi.vh:
  - Z80FI_MAX_MCYCLES
  - Z80FI_TCYC_W
  - a record struct typedef (insn, len, raddr, rdata, waddr, wdata, types[7], tcycles[6], overflow)
- One natural sub-module: z80fi_record_reg. It holds the working record, does the clear-and-load-slot-1 on retire, and the copy to the output struct.

Test Plan:
- Reset mid-record: events, then reset_n low for 1 clk, then release -> all outputs 0/`CYCLE_NONE`, no valid pulse.
- SRL (IX+5), 32'b001??110 form 0x3E05CBDD:
  - Stimulus: cycles M1(4T) DD, M1(4T) CB, RDWR(3T) 05, RDWR(5T) 3E, RDWR(4T) read 0x1005 = 0x81, RDWR(3T) write 0x40, insn_done.
  - Required: insn = 0x3E05CBDD, len = 4, types M1, M1, RDWR×4, NONE; tcycles 4,4,3,5,4,3; raddr = waddr = 0x1005, rdata = 0x81, wdata = 0x40; valid 1 clk.
- Overlap: insn_done together with cyc_start(M1) and t_tick -> the retired record lacks that cycle; the next record has type1 = M1, tcycles1 = 4 after 3 more ticks.
- Overflow: 8 cyc_starts plus 5 insn bytes, then insn_done -> overflow = 1, type7 = 7th type, insn holds the first 4 bytes, len = 4.
- Saturation: 9 ticks in one cycle -> tcycles = 7.
- Two writes 0x2000 = 0x11 then 0x2001 = 0x22 -> waddr = 0x2000, wdata = 0x11.

Source files
------------

// File: rtl/z80fi_bus_recorder_pkg.sv
// Shared types for the z80fi producer side: cycle codes, interface sizing and the record layout.
package z80fi_bus_recorder_pkg;

    localparam int Z80FI_MAX_MCYCLES = 7;
    localparam int Z80FI_TCYC_W      = 3;
    localparam int Z80FI_TSLOTS      = Z80FI_MAX_MCYCLES - 1;
    localparam int Z80FI_MAX_BYTES   = 4;

    localparam logic [2:0] CYCLE_NONE     = 3'd0;
    localparam logic [2:0] CYCLE_M1       = 3'd1;
    localparam logic [2:0] CYCLE_RDWR     = 3'd2;
    localparam logic [2:0] CYCLE_IO       = 3'd3;
    localparam logic [2:0] CYCLE_INTA     = 3'd4;
    localparam logic [2:0] CYCLE_NMI      = 3'd5;
    localparam logic [2:0] CYCLE_INTERNAL = 3'd6;
    localparam logic [2:0] CYCLE_BUSREQ   = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_RECORD
    } rec_state_t;

    typedef struct packed {
        logic [31:0]                                    insn;
        logic [2:0]                                     len;
        logic [15:0]                                    raddr;
        logic [7:0]                                     rdata;
        logic [15:0]                                    waddr;
        logic [7:0]                                     wdata;
        logic [Z80FI_MAX_MCYCLES-1:0][2:0]              types;
        logic [Z80FI_TSLOTS-1:0][Z80FI_TCYC_W-1:0]      tcycles;
        logic                                           overflow;
    } z80fi_rec_t;

    function automatic logic [Z80FI_TCYC_W-1:0] tcyc_inc(input logic [Z80FI_TCYC_W-1:0] v);
        return (&v) ? v : v + Z80FI_TCYC_W'(1);
    endfunction

endpackage

// File: rtl/z80fi_record_reg.sv
// Working instruction record plus the retired copy presented on the z80fi outputs.
module z80fi_record_reg
    import z80fi_bus_recorder_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        retire,
    input  logic        first_cycle,
    input  logic        tick_en,
    input  logic        cyc_start,
    input  logic [2:0]  cyc_type,
    input  logic        t_tick,
    input  logic [15:0] bus_addr,
    input  logic        bus_rd,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_wr,
    input  logic [7:0]  bus_wdata,
    input  logic        insn_byte,
    output z80fi_rec_t  out_rec,
    output logic        out_valid
);

    localparam logic [2:0] SLOT_LAST  = 3'(Z80FI_MAX_MCYCLES);
    localparam logic [2:0] TSLOT_LAST = 3'(Z80FI_TSLOTS);
    localparam logic [2:0] BYTES_MAX  = 3'(Z80FI_MAX_BYTES);

    z80fi_rec_t work, cur, nxt;
    logic [2:0] slot, slot_idx, base_slot, nxt_slot;
    logic       rd_seen, wr_seen, rd_seen_nx, wr_seen_nx, nxt_rd_seen, nxt_wr_seen;

    always_comb begin
        // cur: the current record with this clk's events, excluding any cycle start
        cur        = work;
        slot_idx   = slot - 3'd1;
        rd_seen_nx = rd_seen;
        wr_seen_nx = wr_seen;

        if (tick_en && t_tick && !cyc_start && slot != 3'd0 && slot < SLOT_LAST)
            cur.tcycles[slot_idx] = tcyc_inc(cur.tcycles[slot_idx]);

        if (bus_rd) begin
            if (insn_byte) begin
                if (cur.len < BYTES_MAX) begin
                    cur.insn[{cur.len[1:0], 3'b000} +: 8] = bus_rdata;
                    cur.len = cur.len + 3'd1;
                end else begin
                    cur.overflow = 1'b1;
                end
            end else if (!rd_seen) begin
                cur.raddr  = bus_addr;
                cur.rdata  = bus_rdata;
                rd_seen_nx = 1'b1;
            end
        end

        if (bus_wr && !wr_seen) begin
            cur.waddr  = bus_addr;
            cur.wdata  = bus_wdata;
            wr_seen_nx = 1'b1;
        end

        // A cycle starting on the retire clk opens the fresh record instead
        nxt         = retire ? '0 : cur;
        base_slot   = (retire || first_cycle) ? 3'd0 : slot;
        nxt_rd_seen = retire ? 1'b0 : rd_seen_nx;
        nxt_wr_seen = retire ? 1'b0 : wr_seen_nx;
        nxt_slot    = base_slot;

        if (cyc_start) begin
            if (base_slot < SLOT_LAST) begin
                nxt.types[base_slot] = cyc_type;
                if (base_slot < TSLOT_LAST)
                    nxt.tcycles[base_slot] = Z80FI_TCYC_W'(t_tick);
                nxt_slot = base_slot + 3'd1;
            end else begin
                nxt.overflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work      <= '0;
            slot      <= 3'd0;
            rd_seen   <= 1'b0;
            wr_seen   <= 1'b0;
            out_rec   <= '0;
            out_valid <= 1'b0;
        end else begin
            work      <= nxt;
            slot      <= nxt_slot;
            rd_seen   <= nxt_rd_seen;
            wr_seen   <= nxt_wr_seen;
            out_valid <= retire;
            if (retire)
                out_rec <= cur;
        end
    end

endmodule

// File: rtl/z80fi_bus_recorder.sv
// z80fi producer: tracks instruction boundaries and exposes each retired record as z80fi_* signals.
//  state     | meaning
//  ST_IDLE   | no cycle recorded yet for the current instruction
//  ST_RECORD | at least one cycle in the working record
module z80fi_bus_recorder
    import z80fi_bus_recorder_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cyc_start,
    input  logic [2:0]              cyc_type,
    input  logic                    t_tick,
    input  logic [15:0]             bus_addr,
    input  logic                    bus_rd,
    input  logic [7:0]              bus_rdata,
    input  logic                    bus_wr,
    input  logic [7:0]              bus_wdata,
    input  logic                    insn_byte,
    input  logic                    insn_done,
    output logic                    z80fi_valid,
    output logic [31:0]             z80fi_insn,
    output logic [2:0]              z80fi_insn_len,
    output logic [15:0]             z80fi_bus_raddr,
    output logic [7:0]              z80fi_bus_rdata,
    output logic [15:0]             z80fi_bus_waddr,
    output logic [7:0]              z80fi_bus_wdata,
    output logic [2:0]              z80fi_mcycle_type1,
    output logic [2:0]              z80fi_mcycle_type2,
    output logic [2:0]              z80fi_mcycle_type3,
    output logic [2:0]              z80fi_mcycle_type4,
    output logic [2:0]              z80fi_mcycle_type5,
    output logic [2:0]              z80fi_mcycle_type6,
    output logic [2:0]              z80fi_mcycle_type7,
    output logic [Z80FI_TCYC_W-1:0] z80fi_tcycles1,
    output logic [Z80FI_TCYC_W-1:0] z80fi_tcycles2,
    output logic [Z80FI_TCYC_W-1:0] z80fi_tcycles3,
    output logic [Z80FI_TCYC_W-1:0] z80fi_tcycles4,
    output logic [Z80FI_TCYC_W-1:0] z80fi_tcycles5,
    output logic [Z80FI_TCYC_W-1:0] z80fi_tcycles6,
    output logic                    z80fi_overflow
);

    rec_state_t state_q, state_d;
    logic       retire, first_cycle, tick_en;
    z80fi_rec_t out_rec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        retire      = insn_done;
        first_cycle = 1'b0;
        tick_en     = (state_q == ST_RECORD);
        case (state_q)
            ST_IDLE: begin
                if (cyc_start) begin
                    state_d     = ST_RECORD;
                    first_cycle = 1'b1;
                end
            end
            ST_RECORD: begin
                if (insn_done) begin
                    state_d     = cyc_start ? ST_RECORD : ST_IDLE;
                    first_cycle = cyc_start;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    z80fi_record_reg u_record_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .retire     (retire),
        .first_cycle(first_cycle),
        .tick_en    (tick_en),
        .cyc_start  (cyc_start),
        .cyc_type   (cyc_type),
        .t_tick     (t_tick),
        .bus_addr   (bus_addr),
        .bus_rd     (bus_rd),
        .bus_rdata  (bus_rdata),
        .bus_wr     (bus_wr),
        .bus_wdata  (bus_wdata),
        .insn_byte  (insn_byte),
        .out_rec    (out_rec),
        .out_valid  (z80fi_valid)
    );

    assign z80fi_insn         = out_rec.insn;
    assign z80fi_insn_len     = out_rec.len;
    assign z80fi_bus_raddr    = out_rec.raddr;
    assign z80fi_bus_rdata    = out_rec.rdata;
    assign z80fi_bus_waddr    = out_rec.waddr;
    assign z80fi_bus_wdata    = out_rec.wdata;
    assign z80fi_mcycle_type1 = out_rec.types[0];
    assign z80fi_mcycle_type2 = out_rec.types[1];
    assign z80fi_mcycle_type3 = out_rec.types[2];
    assign z80fi_mcycle_type4 = out_rec.types[3];
    assign z80fi_mcycle_type5 = out_rec.types[4];
    assign z80fi_mcycle_type6 = out_rec.types[5];
    assign z80fi_mcycle_type7 = out_rec.types[6];
    assign z80fi_tcycles1     = out_rec.tcycles[0];
    assign z80fi_tcycles2     = out_rec.tcycles[1];
    assign z80fi_tcycles3     = out_rec.tcycles[2];
    assign z80fi_tcycles4     = out_rec.tcycles[3];
    assign z80fi_tcycles5     = out_rec.tcycles[4];
    assign z80fi_tcycles6     = out_rec.tcycles[5];
    assign z80fi_overflow     = out_rec.overflow;

endmodule

// File: tb/tb_z80fi_bus_recorder.sv
// Directed bench for z80fi_bus_recorder: a vector table of single-clk beats plus multi-cycle sequences.
module tb_z80fi_bus_recorder;
    import z80fi_bus_recorder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cyc_start, t_tick, bus_rd, bus_wr, insn_byte, insn_done;
    logic [2:0]  cyc_type;
    logic [15:0] bus_addr;
    logic [7:0]  bus_rdata, bus_wdata;
    logic        z80fi_valid, z80fi_overflow;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_bus_raddr, z80fi_bus_waddr;
    logic [7:0]  z80fi_bus_rdata, z80fi_bus_wdata;
    logic [2:0]  ty1, ty2, ty3, ty4, ty5, ty6, ty7;
    logic [2:0]  tc1, tc2, tc3, tc4, tc5, tc6;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    z80fi_bus_recorder dut (
        .clk(clk), .reset_n(reset_n),
        .cyc_start(cyc_start), .cyc_type(cyc_type), .t_tick(t_tick),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_rdata(bus_rdata),
        .bus_wr(bus_wr), .bus_wdata(bus_wdata),
        .insn_byte(insn_byte), .insn_done(insn_done),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_bus_raddr(z80fi_bus_raddr), .z80fi_bus_rdata(z80fi_bus_rdata),
        .z80fi_bus_waddr(z80fi_bus_waddr), .z80fi_bus_wdata(z80fi_bus_wdata),
        .z80fi_mcycle_type1(ty1), .z80fi_mcycle_type2(ty2), .z80fi_mcycle_type3(ty3),
        .z80fi_mcycle_type4(ty4), .z80fi_mcycle_type5(ty5), .z80fi_mcycle_type6(ty6),
        .z80fi_mcycle_type7(ty7),
        .z80fi_tcycles1(tc1), .z80fi_tcycles2(tc2), .z80fi_tcycles3(tc3),
        .z80fi_tcycles4(tc4), .z80fi_tcycles5(tc5), .z80fi_tcycles6(tc6),
        .z80fi_overflow(z80fi_overflow)
    );

    typedef struct packed {
        logic        cs;
        logic [2:0]  ct;
        logic        tk;
        logic        rd;
        logic        ib;
        logic [7:0]  rdat;
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdat;
        logic        done;
    } beat_t;

    typedef struct packed {
        beat_t       b;
        logic        chk;
        logic        exp_valid;
        logic [2:0]  exp_len;
        logic [31:0] exp_insn;
        logic [2:0]  exp_t1;
        logic [2:0]  exp_tc1;
        logic [2:0]  exp_t2;
        logic [2:0]  exp_tc2;
    } vec_t;

    vec_t tbl [16];

    function automatic beat_t bt(logic cs, logic [2:0] ct, logic tk, logic rd, logic ib,
                                 logic [7:0] rdat, logic done);
        beat_t b = '0;
        b.cs = cs; b.ct = ct; b.tk = tk; b.rd = rd; b.ib = ib; b.rdat = rdat; b.done = done;
        return b;
    endfunction

    function automatic vec_t mkv(beat_t b, logic chk, logic v, logic [2:0] len, logic [31:0] insn,
                                 logic [2:0] t1, logic [2:0] c1, logic [2:0] t2, logic [2:0] c2);
        vec_t r;
        r.b = b; r.chk = chk; r.exp_valid = v; r.exp_len = len; r.exp_insn = insn;
        r.exp_t1 = t1; r.exp_tc1 = c1; r.exp_t2 = t2; r.exp_tc2 = c2;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input beat_t b);
        cyc_start = b.cs;  cyc_type  = b.ct;   t_tick    = b.tk;
        bus_rd    = b.rd;  insn_byte = b.ib;   bus_rdata = b.rdat;
        bus_addr  = b.addr; bus_wr   = b.wr;   bus_wdata = b.wdat;
        insn_done = b.done;
    endtask

    task automatic drive(input beat_t b);
        @(negedge clk);
        apply(b);
        @(posedge clk);
        #1;
    endtask

    // One machine cycle of nt T-states; ev is merged into T-state ev_at
    task automatic run_cycle(input logic [2:0] ct, input int nt, input int ev_at, input beat_t ev);
        beat_t b;
        for (int i = 0; i < nt; i++) begin
            b = (i == ev_at) ? ev : '0;
            b.tk = 1'b1;
            if (i == 0) begin
                b.cs = 1'b1;
                b.ct = ct;
            end
            drive(b);
        end
    endtask

    beat_t ev, idle_b, done_b;
    logic [2:0] ovf_types [8];

    initial begin
        idle_b = '0;
        done_b = '0;
        done_b.done = 1'b1;

        tbl[0]  = mkv(bt(0, 0, 0, 0, 0, 8'h00, 0),         1, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[1]  = mkv(bt(0, 0, 0, 0, 0, 8'h00, 1),         1, 1, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[2]  = mkv(bt(0, 0, 0, 0, 0, 8'h00, 1),         1, 1, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[3]  = mkv(bt(0, 0, 0, 0, 0, 8'h00, 0),         0, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[4]  = mkv(bt(1, CYCLE_M1, 1, 1, 1, 8'h3C, 0),  0, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[5]  = mkv(bt(0, 0, 1, 0, 0, 8'h00, 0),         0, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[6]  = mkv(bt(0, 0, 1, 0, 0, 8'h00, 0),         0, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[7]  = mkv(bt(0, 0, 1, 0, 0, 8'h00, 1),         1, 1, 1, 32'h3C, CYCLE_M1, 4, CYCLE_NONE, 0);
        tbl[8]  = mkv(bt(1, CYCLE_M1, 1, 1, 1, 8'h06, 0),  1, 0, 1, 32'h3C, CYCLE_M1, 4, CYCLE_NONE, 0);
        tbl[9]  = mkv(bt(0, 0, 1, 0, 0, 8'h00, 0),         0, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[10] = mkv(bt(0, 0, 1, 0, 0, 8'h00, 0),         0, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[11] = mkv(bt(0, 0, 1, 0, 0, 8'h00, 0),         0, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[12] = mkv(bt(1, CYCLE_RDWR, 1, 1, 1, 8'h7F, 0), 0, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[13] = mkv(bt(0, 0, 1, 0, 0, 8'h00, 0),         0, 0, 0, 32'h0, CYCLE_NONE, 0, CYCLE_NONE, 0);
        tbl[14] = mkv(bt(0, 0, 1, 0, 0, 8'h00, 1),         1, 1, 2, 32'h7F06, CYCLE_M1, 4, CYCLE_RDWR, 3);
        tbl[15] = mkv(bt(0, 0, 0, 0, 0, 8'h00, 0),         1, 0, 2, 32'h7F06, CYCLE_M1, 4, CYCLE_RDWR, 3);

        reset_n = 1'b0;
        apply(idle_b);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].b);
            cmp($sformatf("tbl%0d valid", i), 32'(z80fi_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].chk) begin
                cmp($sformatf("tbl%0d len", i),  32'(z80fi_insn_len), 32'(tbl[i].exp_len));
                cmp($sformatf("tbl%0d insn", i), z80fi_insn, tbl[i].exp_insn);
                cmp($sformatf("tbl%0d type1", i), 32'(ty1), 32'(tbl[i].exp_t1));
                cmp($sformatf("tbl%0d tc1", i),   32'(tc1), 32'(tbl[i].exp_tc1));
                cmp($sformatf("tbl%0d type2", i), 32'(ty2), 32'(tbl[i].exp_t2));
                cmp($sformatf("tbl%0d tc2", i),   32'(tc2), 32'(tbl[i].exp_tc2));
            end
        end

        // SRL (IX+5): DD CB 05 3E with a data read and write
        run_cycle(CYCLE_M1,   4, 0, bt(0, 0, 0, 1, 1, 8'hDD, 0));
        run_cycle(CYCLE_M1,   4, 0, bt(0, 0, 0, 1, 1, 8'hCB, 0));
        run_cycle(CYCLE_RDWR, 3, 0, bt(0, 0, 0, 1, 1, 8'h05, 0));
        run_cycle(CYCLE_RDWR, 5, 0, bt(0, 0, 0, 1, 1, 8'h3E, 0));
        ev = bt(0, 0, 0, 1, 0, 8'h81, 0);
        ev.addr = 16'h1005;
        run_cycle(CYCLE_RDWR, 4, 2, ev);
        ev = '0;
        ev.wr = 1'b1; ev.addr = 16'h1005; ev.wdat = 8'h40;
        run_cycle(CYCLE_RDWR, 3, 1, ev);
        cmp("srl pre valid", 32'(z80fi_valid), 32'd0);
        drive(done_b);
        cmp("srl valid", 32'(z80fi_valid), 32'd1);
        cmp("srl insn", z80fi_insn, 32'h3E05CBDD);
        cmp("srl len", 32'(z80fi_insn_len), 32'd4);
        cmp("srl types", {ty1, ty2, ty3, ty4, ty5, ty6, ty7},
            32'({CYCLE_M1, CYCLE_M1, CYCLE_RDWR, CYCLE_RDWR, CYCLE_RDWR, CYCLE_RDWR, CYCLE_NONE}));
        cmp("srl tcycles", {tc1, tc2, tc3, tc4, tc5, tc6},
            32'({3'd4, 3'd4, 3'd3, 3'd5, 3'd4, 3'd3}));
        cmp("srl raddr", 32'(z80fi_bus_raddr), 32'h1005);
        cmp("srl rdata", 32'(z80fi_bus_rdata), 32'h81);
        cmp("srl waddr", 32'(z80fi_bus_waddr), 32'h1005);
        cmp("srl wdata", 32'(z80fi_bus_wdata), 32'h40);
        cmp("srl overflow", 32'(z80fi_overflow), 32'd0);
        drive(idle_b);
        cmp("srl valid drop", 32'(z80fi_valid), 32'd0);

        // insn_done coincident with the next instruction's first cycle
        run_cycle(CYCLE_RDWR, 2, -1, '0);
        drive(bt(1, CYCLE_M1, 1, 0, 0, 8'h00, 1));
        cmp("ovl valid", 32'(z80fi_valid), 32'd1);
        cmp("ovl type1", 32'(ty1), 32'(CYCLE_RDWR));
        cmp("ovl tc1", 32'(tc1), 32'd2);
        cmp("ovl type2", 32'(ty2), 32'(CYCLE_NONE));
        for (int i = 0; i < 3; i++) drive(bt(0, 0, 1, 0, 0, 8'h00, 0));
        cmp("ovl gap valid", 32'(z80fi_valid), 32'd0);
        drive(done_b);
        cmp("ovl2 valid", 32'(z80fi_valid), 32'd1);
        cmp("ovl2 type1", 32'(ty1), 32'(CYCLE_M1));
        cmp("ovl2 tc1", 32'(tc1), 32'd4);
        cmp("ovl2 type2", 32'(ty2), 32'(CYCLE_NONE));

        // Eight cycles and five instruction bytes
        ovf_types = '{CYCLE_M1, CYCLE_RDWR, CYCLE_IO, CYCLE_M1, CYCLE_RDWR, CYCLE_IO, CYCLE_INTA, CYCLE_M1};
        for (int i = 0; i < 8; i++) begin
            if (i < 5) ev = bt(0, 0, 0, 1, 1, 8'(8'h11 * (i + 1)), 0);
            else       ev = '0;
            run_cycle(ovf_types[i], 1, 0, ev);
        end
        drive(done_b);
        cmp("ovf valid", 32'(z80fi_valid), 32'd1);
        cmp("ovf overflow", 32'(z80fi_overflow), 32'd1);
        cmp("ovf insn", z80fi_insn, 32'h44332211);
        cmp("ovf len", 32'(z80fi_insn_len), 32'd4);
        cmp("ovf type6", 32'(ty6), 32'(CYCLE_IO));
        cmp("ovf type7", 32'(ty7), 32'(CYCLE_INTA));
        cmp("ovf tc6", 32'(tc6), 32'd1);

        // Saturation, two writes and two data reads in one cycle
        for (int i = 0; i < 9; i++) begin
            ev = '0;
            ev.tk = 1'b1;
            case (i)
                0: begin ev.cs = 1'b1; ev.ct = CYCLE_RDWR; end
                1: begin ev.wr = 1'b1; ev.addr = 16'h2000; ev.wdat = 8'h11; end
                2: begin ev.wr = 1'b1; ev.addr = 16'h2001; ev.wdat = 8'h22; end
                3: begin ev.rd = 1'b1; ev.addr = 16'h3000; ev.rdat = 8'h5A; end
                4: begin ev.rd = 1'b1; ev.addr = 16'h3001; ev.rdat = 8'hA5; end
                default: ;
            endcase
            drive(ev);
        end
        drive(done_b);
        cmp("sat valid", 32'(z80fi_valid), 32'd1);
        cmp("sat tc1", 32'(tc1), 32'd7);
        cmp("sat waddr", 32'(z80fi_bus_waddr), 32'h2000);
        cmp("sat wdata", 32'(z80fi_bus_wdata), 32'h11);
        cmp("sat raddr", 32'(z80fi_bus_raddr), 32'h3000);
        cmp("sat rdata", 32'(z80fi_bus_rdata), 32'h5A);
        cmp("sat len", 32'(z80fi_insn_len), 32'd0);
        cmp("sat overflow", 32'(z80fi_overflow), 32'd0);

        // Reset in the middle of a record
        run_cycle(CYCLE_M1, 3, 0, bt(0, 0, 0, 1, 1, 8'hED, 0));
        @(negedge clk);
        apply(idle_b);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        cmp("rst valid", 32'(z80fi_valid), 32'd0);
        cmp("rst waddr", 32'(z80fi_bus_waddr), 32'd0);
        cmp("rst raddr", 32'(z80fi_bus_raddr), 32'd0);
        cmp("rst tc1", 32'(tc1), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(bt(0, 0, 1, 0, 0, 8'h00, 0));
        cmp("rst idle valid", 32'(z80fi_valid), 32'd0);
        cmp("rst idle type1", 32'(ty1), 32'(CYCLE_NONE));
        drive(done_b);
        cmp("rst done valid", 32'(z80fi_valid), 32'd1);
        cmp("rst done len", 32'(z80fi_insn_len), 32'd0);
        cmp("rst done insn", z80fi_insn, 32'd0);
        cmp("rst done type1", 32'(ty1), 32'(CYCLE_NONE));
        cmp("rst done tc1", 32'(tc1), 32'd0);
        drive(idle_b);
        cmp("rst final valid", 32'(z80fi_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
